// File: rtl/serial_ctrl_if.sv
// rtl/serial_ctrl_if.sv - host-side transmit/receive handshake bundle for serial_ctrl
interface serial_ctrl_if #(
    parameter int RX_DEPTH = 4
);
    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic [15:0]   tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [15:0]   rx_data;
    logic          rx_valid;
    logic          rx_pop;
    logic [CW-1:0] rx_count;

    modport master (
        output tx_data, tx_valid, rx_pop,
        input  tx_ready, rx_data, rx_valid, rx_count
    );

    modport slave (
        input  tx_data, tx_valid, rx_pop,
        output tx_ready, rx_data, rx_valid, rx_count
    );
endinterface

// File: rtl/serial_ctrl.sv
// rtl/serial_ctrl.sv - UART chip strobe sequencer with TX holding register and RX FIFO
module serial_ctrl #(
    parameter int RD_WAIT  = 2,
    parameter int RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_ready,
    input  logic       tbre,
    input  logic       tsre,
    output logic       rdn,
    output logic       wrn,
    output logic       ram1en,
    output logic       ram1oe,
    output logic       ram1we,
    inout  wire  [7:0] ram1data,
    serial_ctrl_if.slave host
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, RD_LOW, RD_REL, WR_SETUP, WR_LOW, WR_HOLD, WR_TBRE, WR_TSRE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rdn_q, rdn_d;
    logic          wrn_q, wrn_d;
    logic          tx_pend_q, tx_pend_d;
    logic [7:0]    tx_hold_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [7:0]    mem_q [RX_DEPTH];

    logic push, pop, tx_accept, tx_done, fifo_full, bus_drive;
    logic unused_tx_hi;

    assign fifo_full = (count_q == CW'(RX_DEPTH));
    assign tx_accept = host.tx_valid && !tx_pend_q;
    assign pop       = host.rx_pop && (count_q != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        tx_done = 1'b0;
        case (state_q)
            IDLE: begin
                // Receive wins so the chip's single-byte buffer is drained before it overruns.
                if (data_ready && !fifo_full) begin
                    state_d = RD_LOW;
                    cnt_d   = '0;
                end else if (tx_pend_q) begin
                    state_d = WR_SETUP;
                end
            end
            RD_LOW: begin
                if (cnt_q == 4'(RD_WAIT - 1)) begin
                    push    = 1'b1;
                    state_d = RD_REL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RD_REL:   state_d = IDLE;
            WR_SETUP: state_d = WR_LOW;
            WR_LOW:   state_d = WR_HOLD;
            WR_HOLD:  state_d = WR_TBRE;
            WR_TBRE:  if (tbre) state_d = WR_TSRE;
            WR_TSRE: begin
                if (tsre) begin
                    state_d = IDLE;
                    tx_done = 1'b1;
                end
            end
            default:  state_d = IDLE;
        endcase
        tx_pend_d = tx_done ? 1'b0 : (tx_accept ? 1'b1 : tx_pend_q);
        // Strobes are registered copies of the upcoming state, so they never glitch.
        rdn_d = (state_d != RD_LOW);
        wrn_d = (state_d != WR_LOW);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            tx_pend_q <= 1'b0;
            tx_hold_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdn_q     <= rdn_d;
            wrn_q     <= wrn_d;
            tx_pend_q <= tx_pend_d;
            if (tx_accept) tx_hold_q <= host.tx_data[7:0];
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wr_ptr_q] <= ram1data;
    end

    assign bus_drive     = (state_q == WR_SETUP) || (state_q == WR_LOW) || (state_q == WR_HOLD);
    assign ram1data      = bus_drive ? tx_hold_q : 8'hzz;
    assign rdn           = rdn_q;
    assign wrn           = wrn_q;
    assign ram1en        = 1'b1;
    assign ram1oe        = 1'b1;
    assign ram1we        = 1'b1;
    assign host.tx_ready = !tx_pend_q;
    assign host.rx_valid = (count_q != '0);
    assign host.rx_data  = (count_q != '0) ? {8'h00, mem_q[rd_ptr_q]} : 16'h0000;
    assign host.rx_count = count_q;
    assign unused_tx_hi  = ^host.tx_data[15:8];
endmodule

// File: tb/tb_serial_ctrl.sv
// tb/tb_serial_ctrl.sv - scoreboard bench for serial_ctrl with a behavioural UART chip
module tb_serial_ctrl;
    localparam int RX_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_ready = 1'b0;
    logic       tbre = 1'b0;
    logic       tsre = 1'b0;
    logic       rdn, wrn, ram1en, ram1oe, ram1we;
    wire  [7:0] ram1data;
    logic [7:0] uart_byte = 8'h00;
    logic       rdn_prev = 1'b1;

    logic [7:0] uart_q[$];
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    int vectors = 0;
    int miscompares = 0;

    serial_ctrl_if #(.RX_DEPTH(RX_DEPTH)) bus_if ();

    serial_ctrl #(.RD_WAIT(2), .RX_DEPTH(RX_DEPTH)) dut (
        .clk(clk), .rst(rst), .data_ready(data_ready), .tbre(tbre), .tsre(tsre),
        .rdn(rdn), .wrn(wrn), .ram1en(ram1en), .ram1oe(ram1oe), .ram1we(ram1we),
        .ram1data(ram1data), .host(bus_if.slave)
    );

    always #5 clk = ~clk;

    // UART chip: drives its byte only while rdn is low, retires it when rdn rises.
    assign ram1data = rdn ? 8'hzz : uart_byte;

    always @(negedge clk) begin
        if (rdn && !rdn_prev && uart_q.size() > 0) void'(uart_q.pop_front());
        rdn_prev   = rdn;
        data_ready = (uart_q.size() != 0);
        if (uart_q.size() != 0) uart_byte = uart_q[0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents receive data or a write strobe.
    always @(negedge clk) begin
        check("rdn_wrn_exclusive", {31'b0, rdn | wrn}, 32'd1);
        if (bus_if.rx_valid && bus_if.rx_pop) begin
            if (rx_exp.size() == 0) check("rx_unexpected_pop", 32'd1, 32'd0);
            else check("rx_pop_data", {16'h0, bus_if.rx_data}, {24'h0, rx_exp.pop_front()});
        end
        if (!wrn) begin
            if (tx_exp.size() == 0) check("tx_unexpected_write", 32'd1, 32'd0);
            else check("tx_bus_byte", {24'h0, ram1data}, {24'h0, tx_exp.pop_front()});
        end
    end

    task automatic uart_push(input logic [7:0] b);
        uart_q.push_back(b);
        rx_exp.push_back(b);
        data_ready = 1'b1;
        uart_byte  = uart_q[0];
    endtask

    task automatic send_tx(input logic [15:0] d);
        @(posedge clk); #1;
        bus_if.tx_data  = d;
        bus_if.tx_valid = 1'b1;
        tx_exp.push_back(d[7:0]);
        @(posedge clk); #1;
        bus_if.tx_valid = 1'b0;
    endtask

    task automatic pop_one();
        @(posedge clk); #1 bus_if.rx_pop = 1'b1;
        @(posedge clk); #1 bus_if.rx_pop = 1'b0;
    endtask

    task automatic wait_rdn_low(input string name);
        int i = 0;
        @(negedge clk);
        while (rdn !== 1'b0 && i < 60) begin @(negedge clk); i++; end
        check(name, {31'b0, rdn}, 32'd0);
    endtask

    task automatic wait_wrn_low(input string name);
        int i = 0;
        @(negedge clk);
        while (wrn !== 1'b0 && i < 60) begin @(negedge clk); i++; end
        check(name, {31'b0, wrn}, 32'd0);
    endtask

    task automatic wait_count(input string name, input int n);
        int i = 0;
        @(negedge clk);
        while (bus_if.rx_count != n && i < 80) begin @(negedge clk); i++; end
        check(name, 32'(bus_if.rx_count), 32'(n));
    endtask

    task automatic wait_tx_ready(input string name);
        int i = 0;
        @(negedge clk);
        while (bus_if.tx_ready !== 1'b1 && i < 60) begin @(negedge clk); i++; end
        check(name, {31'b0, bus_if.tx_ready}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int first;
        logic [7:0] full_vec [5];
        full_vec = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bus_if.tx_data  = 16'h0000;
        bus_if.tx_valid = 1'b0;
        bus_if.rx_pop   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdn", {31'b0, rdn}, 32'd1);
        check("reset_wrn", {31'b0, wrn}, 32'd1);
        check("reset_tx_ready", {31'b0, bus_if.tx_ready}, 32'd1);
        check("reset_rx_valid", {31'b0, bus_if.rx_valid}, 32'd0);
        check("reset_rx_count", 32'(bus_if.rx_count), 32'd0);
        check("reset_rx_data", {16'h0, bus_if.rx_data}, 32'h0000);
        check("ram1_ctrl_high", {29'b0, ram1en, ram1oe, ram1we}, 32'd7);
        @(posedge clk); #1 rst = 1'b1;

        // Single receive of A5
        uart_push(8'hA5);
        wait_rdn_low("rx_a5_start");
        n = 0;
        while (rdn == 1'b0 && n < 20) begin n++; @(negedge clk); end
        check("rx_a5_rdn_low_cycles", 32'(n), 32'd2);
        check("rx_a5_rdn_release", {31'b0, rdn}, 32'd1);
        check("rx_a5_valid", {31'b0, bus_if.rx_valid}, 32'd1);
        check("rx_a5_data", {16'h0, bus_if.rx_data}, 32'h00A5);
        check("rx_a5_count", 32'(bus_if.rx_count), 32'd1);
        pop_one();
        @(negedge clk);
        check("rx_a5_count_after_pop", 32'(bus_if.rx_count), 32'd0);

        // Transmit 0x1234 -> byte 34
        send_tx(16'h1234);
        @(negedge clk);
        check("tx_ready_busy", {31'b0, bus_if.tx_ready}, 32'd0);
        wait_wrn_low("tx_34_wrn_low");
        @(negedge clk);
        check("tx_hold_wrn_high", {31'b0, wrn}, 32'd1);
        check("tx_hold_bus", {24'h0, ram1data}, 32'h34);
        repeat (3) @(posedge clk);
        #1 begin tbre = 1'b1; tsre = 1'b1; end
        @(negedge clk);
        check("tx_ready_in_tbre", {31'b0, bus_if.tx_ready}, 32'd0);
        @(negedge clk);
        check("tx_ready_in_tsre", {31'b0, bus_if.tx_ready}, 32'd0);
        @(negedge clk);
        check("tx_ready_after_tsre", {31'b0, bus_if.tx_ready}, 32'd1);
        @(posedge clk); #1 begin tbre = 1'b0; tsre = 1'b0; end

        // Receive and transmit requested together: read goes first
        @(posedge clk); #1;
        uart_push(8'h5A);
        bus_if.tx_data  = 16'hFF77;
        bus_if.tx_valid = 1'b1;
        tx_exp.push_back(8'h77);
        @(posedge clk); #1 bus_if.tx_valid = 1'b0;
        first = 0;
        for (int i = 0; i < 40 && first == 0; i++) begin
            @(negedge clk);
            if (!rdn) first = 1;
            else if (!wrn) first = 2;
        end
        check("contention_read_first", 32'(first), 32'd1);
        wait_wrn_low("contention_write_follows");
        @(posedge clk); #1 begin tbre = 1'b1; tsre = 1'b1; end
        wait_tx_ready("contention_tx_done");
        @(posedge clk); #1 begin tbre = 1'b0; tsre = 1'b0; end
        pop_one();

        // Full FIFO holds off the fifth read
        @(posedge clk); #1;
        foreach (full_vec[i]) uart_push(full_vec[i]);
        wait_count("full_fill", 4);
        n = 0;
        repeat (10) begin @(negedge clk); if (!rdn) n++; end
        check("full_no_read", 32'(n), 32'd0);
        check("full_count", 32'(bus_if.rx_count), 32'd4);
        check("full_data_ready_held", {31'b0, data_ready}, 32'd1);
        pop_one();
        wait_count("full_refill", 4);
        repeat (4) pop_one();
        @(negedge clk);
        check("full_drained", 32'(bus_if.rx_count), 32'd0);

        // Push and pop on the same edge at occupancy 2
        @(posedge clk); #1;
        uart_push(8'h66);
        uart_push(8'h77);
        wait_count("simul_prefill", 2);
        @(posedge clk); #1 uart_push(8'h88);
        wait_rdn_low("simul_read_start");
        @(posedge clk); #1 bus_if.rx_pop = 1'b1;
        @(posedge clk); #1 bus_if.rx_pop = 1'b0;
        @(negedge clk);
        check("simul_count", 32'(bus_if.rx_count), 32'd2);
        check("simul_head", {16'h0, bus_if.rx_data}, 32'h0077);
        pop_one();
        pop_one();

        // Reset during WR_LOW
        @(posedge clk); #1 uart_push(8'h9E);
        wait_count("rst_prefill", 1);
        send_tx(16'h00C3);
        wait_wrn_low("rst_wr_low");
        rst = 1'b0;
        rx_exp.delete();
        @(negedge clk);
        check("rst_mid_wrn", {31'b0, wrn}, 32'd1);
        check("rst_mid_rdn", {31'b0, rdn}, 32'd1);
        check("rst_mid_tx_ready", {31'b0, bus_if.tx_ready}, 32'd1);
        check("rst_mid_rx_count", 32'(bus_if.rx_count), 32'd0);
        check("rst_mid_rx_valid", {31'b0, bus_if.rx_valid}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        n = 0;
        repeat (8) begin @(negedge clk); if (!wrn) n++; end
        check("rst_write_discarded", 32'(n), 32'd0);
        @(posedge clk); #1 uart_push(8'h3C);
        wait_count("post_rst_rx", 1);
        pop_one();

        @(negedge clk);
        check("rx_scoreboard_empty", 32'(rx_exp.size()), 32'd0);
        check("tx_scoreboard_empty", 32'(tx_exp.size()), 32'd0);
        check("uart_queue_empty", 32'(uart_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_ctrl.md
SERIAL_CTRL -- requirements
Module: serial_ctrl

Interface
REQ-001 Parameter RD_WAIT, default 2: cycles rdn is held low before the receive byte is sampled (legal range 1..15).
REQ-002 Parameter RX_DEPTH, default 4: receive FIFO entries (power of two, 2..16).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  system clock (50 MHz board clock); all state changes on its rising edge.
REQ-005 rst  input  1  synchronous reset, active low.
REQ-006 data_ready  input  1  UART chip has a received byte.
REQ-007 tbre  input  1  UART transmit buffer empty.
REQ-008 tsre  input  1  UART transmit shift register empty.
REQ-009 rdn  output  1  UART read strobe, active low.
REQ-010 wrn  output  1  UART write strobe, active low.
REQ-011 ram1en, ram1oe, ram1we  output  1 each  RAM1 controls, held at 1 constantly so RAM1 never drives the shared bus.
REQ-012 ram1data  inout  8  shared RAM1/UART data bus.
REQ-013 tx_data  input  16  byte to send in [7:0]; [15:8] ignored.
REQ-014 tx_valid  input  1  host offers tx_data.
REQ-015 tx_ready  output  1  block can accept a byte.
REQ-016 rx_data  output  16  {8'h00, FIFO head byte}.
REQ-017 rx_valid  output  1  FIFO not empty.
REQ-018 rx_pop  input  1  host consumes the head entry.
REQ-019 rx_count  output  clog2(RX_DEPTH)+1  FIFO occupancy.

Function
REQ-020 TX handshake: byte accepted on a cycle with tx_valid=1 and tx_ready=1; tx_data[7:0] latched into a holding register; tx_ready=0 from the next cycle until the transfer completes.
REQ-021 States: IDLE, RD_LOW, RD_REL, WR_SETUP, WR_LOW, WR_HOLD, WR_TBRE, WR_TSRE.
REQ-022 IDLE arbitration: if data_ready=1 and FIFO not full -> RD_LOW; else if a TX byte is pending -> WR_SETUP; else stay. Receive has priority over transmit.
REQ-023 RD_LOW: rdn=0, bus tri-stated, RD_WAIT cycles; on the last cycle ram1data is pushed into the FIFO; then -> RD_REL.
REQ-024 RD_REL: rdn=1 for one cycle, then -> IDLE; data_ready is not sampled in RD_REL.
REQ-025 WR_SETUP: holding byte driven on ram1data, wrn=1, one cycle; WR_LOW: wrn=0, one cycle; WR_HOLD: wrn=1, bus still driven, one cycle; then -> WR_TBRE.
REQ-026 WR_TBRE: bus tri-stated, waits for tbre=1 -> WR_TSRE; WR_TSRE waits for tsre=1 -> IDLE, pending flag cleared, tx_ready=1 on the following cycle.
REQ-027 ram1data is driven only in WR_SETUP, WR_LOW and WR_HOLD; in every other state it is high-Z.
REQ-028 rdn and wrn are never low in the same cycle; both are registered outputs.
REQ-029 FIFO is first-word-fall-through: rx_data shows the head byte whenever rx_valid=1; rx_pop with rx_valid=0 is ignored.
REQ-030 Simultaneous push and pop: both take effect; rx_count unchanged; the pushed byte lands behind the existing entries.
REQ-031 Full FIFO: no read starts; data_ready stays pending on the chip; transmit may proceed meanwhile.
REQ-032 Pointers wrap modulo RX_DEPTH; rx_count ranges 0..RX_DEPTH.

Reset
REQ-033 With rst=0 at a clock edge: state=IDLE, rdn=1, wrn=1, ram1data high-Z, FIFO empty (rx_count=0, rx_valid=0, rx_data=16'h0000), TX pending flag cleared, tx_ready=1.
REQ-034 Reset mid-operation (any state) aborts the transfer at that edge; a partially written byte is discarded; the FIFO is emptied.

Verification
REQ-035 Receive: data_ready=1, bus=8'hA5, RD_WAIT=2 -> rdn low for exactly 2 cycles, 1 cycle high, then rx_valid=1, rx_data=16'h00A5, rx_count=1.
REQ-036 Transmit: tx_data=16'h1234, tx_valid pulse; tbre and tsre rise 5 cycles later -> bus=8'h34 for 3 cycles, wrn low for 1 cycle, tx_ready=1 again one cycle after tsre=1 is seen.
REQ-037 Contention: data_ready=1 and tx_valid=1 in the same cycle while in IDLE -> read completes first, then write; rdn and wrn are never low together.
REQ-038 Full FIFO: push 4 bytes (11,22,33,44) without popping and hold data_ready=1 -> no fifth rdn pulse; one rx_pop -> next read starts; pop order is 11,22,33,44, then the fifth byte.
REQ-039 Push and pop in the same cycle at rx_count=2 -> rx_count stays 2 and order is preserved.
REQ-040 Reset asserted during WR_LOW -> next cycle wrn=1, bus high-Z, tx_ready=1, rx_count=0.
